// File: rtl/hack_fetch_unit_pkg.sv
// hack_fetch_unit_pkg
//  Shared definitions for the Hack fetch stage: address/data widths, FSM state
//  encoding and the next-PC selector.
//  Optional feature macro used by the fetch unit: HACK_FETCH_WRAP_TRAP_EN.
package hack_fetch_unit_pkg;

  localparam int HACK_ADDR_W = 15;
  localparam int HACK_DATA_W = 16;

  // 2'd3 is unused; the FSM treats it as illegal and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Mux16-style two-way selector for the next PC: sel=0 -> a, sel=1 -> b.
  // Sized to the package address width.
  function automatic logic [HACK_ADDR_W-1:0] pc_mux(
    input logic                   sel,
    input logic [HACK_ADDR_W-1:0] a,
    input logic [HACK_ADDR_W-1:0] b
  );
    return sel ? b : a;
  endfunction

endpackage

// File: rtl/hack_fetch_unit_if.sv
// hack_fetch_unit_if
//  Bus bundle of the fetch unit: ROM read handshake (req/ack) plus the
//  instruction valid/ready handshake toward decode, including the jump inputs
//  that are sampled on the accept cycle.
//  master : fetch unit side (drives rom_req/rom_addr/instr/instr_valid)
//  slave  : ROM + decode side (drives rom_ack/rom_data/instr_ready/load/jump_addr)
interface hack_fetch_unit_if
  import hack_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = HACK_ADDR_W,
  parameter int DATA_W = HACK_DATA_W
);
  logic              rom_req;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_ack;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              instr_ready;
  logic              load;
  logic [ADDR_W-1:0] jump_addr;

  modport master (
    output rom_req, rom_addr, instr, instr_valid,
    input  rom_ack, rom_data, instr_ready, load, jump_addr
  );

  modport slave (
    input  rom_req, rom_addr, instr, instr_valid,
    output rom_ack, rom_data, instr_ready, load, jump_addr
  );
endinterface

// File: rtl/hack_pc_inc.sv
// hack_pc_inc
//  Combinational ADDR_W-bit incrementer. carry is set when a is all-ones and
//  the sum wraps to zero.
//  a     in   ADDR_W  current PC
//  y     out  ADDR_W  a + 1 (modulo 2^ADDR_W)
//  carry out  1       carry-out of the increment
module hack_pc_inc
  import hack_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = HACK_ADDR_W
) (
  input  logic [ADDR_W-1:0] a,
  output logic [ADDR_W-1:0] y,
  output logic              carry
);
  assign {carry, y} = {1'b0, a} + {{ADDR_W{1'b0}}, 1'b1};
endmodule

// File: rtl/hack_fetch_unit.sv
// hack_fetch_unit
//  PC + instruction fetch stage of the Hack CPU. Fetches the instruction at pc
//  over the ROM req/ack handshake, registers it and offers it to decode on a
//  valid/ready handshake. On accept the PC advances to pc+1 or to jump_addr
//  (when load). No prefetch: FETCH and HOLD never overlap.
//  Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   halt         1 = do not start a new fetch (in-flight handshakes finish)
//   bus          hack_fetch_unit_if.master (ROM + instruction handshakes)
//   pc           address of the instruction being fetched / held
//   wrap_err     sticky PC-overflow flag (only with the trap compiled in)
//  Macro HACK_FETCH_WRAP_TRAP_EN: when defined, an accept with load=0 at
//   pc=all-ones sets wrap_err, keeps pc and parks the FSM in IDLE until reset.
//   When undefined the PC wraps silently and wrap_err is 0.
module hack_fetch_unit
  import hack_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W    = HACK_ADDR_W,
  parameter int                DATA_W    = HACK_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt,
  hack_fetch_unit_if.master bus,
  output logic [ADDR_W-1:0] pc,
  output logic              wrap_err
);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] instr_q;
  logic [ADDR_W-1:0] pc_inc, pc_nxt;
  logic              carry;
  logic              accept;
  logic              trap;

  hack_pc_inc #(.ADDR_W(ADDR_W)) u_pc_inc (
    .a     (pc),
    .y     (pc_inc),
    .carry (carry)
  );

  assign accept = (state == ST_HOLD) && bus.instr_ready;
  assign pc_nxt = pc_mux(bus.load, pc_inc, bus.jump_addr);

`ifdef HACK_FETCH_WRAP_TRAP_EN
  // Overflow only counts on a sequential step; a jump from all-ones is legal.
  assign trap = accept && !bus.load && carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    wrap_err <= 1'b0;
    else if (trap) wrap_err <= 1'b1;
  end
`else
  logic unused_carry;
  assign unused_carry = carry;
  assign trap         = 1'b0;
  assign wrap_err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      // A set wrap_err keeps the unit parked here regardless of halt.
      ST_IDLE:  if (!halt && !wrap_err) state_nxt = ST_FETCH;
      ST_FETCH: if (bus.rom_ack)        state_nxt = ST_HOLD;
      ST_HOLD:  if (accept)             state_nxt = (halt || trap) ? ST_IDLE : ST_FETCH;
      default:                          state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_VEC;
      instr_q <= '0;
    end else begin
      if (state == ST_FETCH && bus.rom_ack) instr_q <= bus.rom_data;
      if (accept && !trap)                  pc      <= pc_nxt;
    end
  end

  // Decoded straight from the state flop, so rom_req falls as soon as rst_n does.
  assign bus.rom_req     = (state == ST_FETCH);
  assign bus.rom_addr    = pc;
  assign bus.instr_valid = (state == ST_HOLD);
  assign bus.instr       = instr_q;

endmodule

// File: tb/tb_hack_fetch_unit.sv
module tb_hack_fetch_unit;
  import hack_fetch_unit_pkg::*;

  localparam int AW = 15;
  localparam int DW = 16;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          halt = 1'b1;
  logic [AW-1:0] pc;
  logic          wrap_err;

  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  int   ack_delay  = 0;
  int   wait_cnt   = 0;
  exp_t sb[$];

  hack_fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  hack_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_VEC(15'd0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .halt     (halt),
    .bus      (bus),
    .pc       (pc),
    .wrap_err (wrap_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM model: fixed content, ack after ack_delay cycles of a held request.
  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    if (a == 15'd5) return 16'hABCD;
    return {1'b0, a} ^ 16'h5A5A;
  endfunction

  function automatic exp_t mk(input logic [AW-1:0] a);
    exp_t e;
    e.addr = a;
    e.data = rom_fn(a);
    return e;
  endfunction

  always @(posedge clk) begin
    if (!bus.rom_req || bus.rom_ack) wait_cnt <= 0;
    else                             wait_cnt <= wait_cnt + 1;
  end
  assign bus.rom_ack  = bus.rom_req && (wait_cnt >= ack_delay);
  assign bus.rom_data = bus.rom_req ? rom_fn(bus.rom_addr) : 16'hDEAD;

  // Scoreboard monitor: every accepted instruction must match the queue head.
  initial forever begin
    @(negedge clk);
    if (rst_n && bus.instr_valid && bus.instr_ready) begin
      exp_t e;
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL accept_unexpected pc=%h instr=%h", pc, bus.instr);
      end else begin
        e = sb.pop_front();
        if (bus.instr !== e.data || pc !== e.addr) begin
          mismatched++;
          $display("FAIL accept_data got pc=%h instr=%h want pc=%h instr=%h",
                   pc, bus.instr, e.addr, e.data);
        end
      end
    end
  end

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (bus.instr_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; halt = 1'b1; ack_delay = 0;
    bus.instr_ready = 1'b0; bus.load = 1'b0; bus.jump_addr = '0;
    repeat (2) @(posedge clk); #1;
    compared++; if (bus.rom_req !== 1'b0) begin mismatched++; $display("FAIL reset_rom_req got %b want 0", bus.rom_req); end
    compared++; if (bus.instr_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid got %b want 0", bus.instr_valid); end
    compared++; if (pc !== 15'd0) begin mismatched++; $display("FAIL reset_pc got %h want 0", pc); end
    compared++; if (bus.instr !== 16'd0) begin mismatched++; $display("FAIL reset_instr got %h want 0", bus.instr); end
    compared++; if (wrap_err !== 1'b0) begin mismatched++; $display("FAIL reset_wrap_err got %b want 0", wrap_err); end
    rst_n = 1'b1;
  endtask

  task automatic test_sequential;
    int t[3];
    bit ok;
    halt = 1'b0; bus.instr_ready = 1'b1; ack_delay = 0;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(mk(AW'(i)));
      wait_valid(ok);
      compared++; if (!ok) begin mismatched++; $display("FAIL seq_timeout got no valid want valid instr %0d", i); end
      t[i] = cyc;
      if (i == 2) halt = 1'b1;
    end
    compared++; if (t[1] - t[0] != 2) begin mismatched++; $display("FAIL seq_spacing01 got %0d want 2", t[1] - t[0]); end
    compared++; if (t[2] - t[1] != 2) begin mismatched++; $display("FAIL seq_spacing12 got %0d want 2", t[2] - t[1]); end
    repeat (3) @(posedge clk); #1;
    compared++; if (bus.rom_req !== 1'b0 || bus.instr_valid !== 1'b0) begin mismatched++; $display("FAIL seq_halt_idle got req=%b valid=%b want 0/0", bus.rom_req, bus.instr_valid); end
    compared++; if (pc !== 15'd3) begin mismatched++; $display("FAIL seq_pc got %h want 0003", pc); end
  endtask

  task automatic test_rom_delay;
    bit ok, got;
    int n;
    bit addr_ok;
    halt = 1'b0; bus.instr_ready = 1'b1; ack_delay = 0;
    sb.push_back(mk(15'd3));
    wait_valid(ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL delay_pre_timeout got no valid want valid"); end
    bus.load = 1'b1; bus.jump_addr = 15'd5; ack_delay = 3;
    @(posedge clk); #1;
    bus.load = 1'b0;
    sb.push_back(mk(15'd5));
    n = 0; got = 1'b0; addr_ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (bus.instr_valid) begin
        got = 1'b1;
        break;
      end
      if (bus.rom_req) begin
        n++;
        if (bus.rom_addr !== 15'd5) addr_ok = 1'b0;
      end
      @(posedge clk); #1;
    end
    halt = 1'b1;
    compared++; if (!got) begin mismatched++; $display("FAIL delay_timeout got no valid want valid"); end
    compared++; if (n != 4) begin mismatched++; $display("FAIL delay_req_cycles got %0d want 4", n); end
    compared++; if (!addr_ok) begin mismatched++; $display("FAIL delay_rom_addr got other want 0005"); end
    compared++; if (bus.instr !== 16'hABCD) begin mismatched++; $display("FAIL delay_instr got %h want abcd", bus.instr); end
    ack_delay = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_jump;
    bit ok;
    bus.instr_ready = 1'b0; halt = 1'b0;
    wait_valid(ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL jump_timeout got no valid want valid"); end
    bus.load = 1'b1; bus.jump_addr = 15'h0200;
    repeat (2) @(posedge clk); #1;
    compared++; if (pc !== 15'd6 || bus.instr_valid !== 1'b1) begin mismatched++; $display("FAIL jump_ignored got pc=%h valid=%b want 0006/1", pc, bus.instr_valid); end
    sb.push_back(mk(15'd6));
    bus.jump_addr = 15'h0100; bus.instr_ready = 1'b1;
    @(posedge clk); #1;
    bus.load = 1'b0;
    compared++; if (bus.rom_req !== 1'b1 || bus.rom_addr !== 15'h0100) begin mismatched++; $display("FAIL jump_target got req=%b addr=%h want 1/0100", bus.rom_req, bus.rom_addr); end
    sb.push_back(mk(15'h0100));
    wait_valid(ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL jump_fetch_timeout got no valid want valid"); end
    halt = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_stall;
    bit ok;
    bit stable;
    bus.instr_ready = 1'b0; halt = 1'b0;
    wait_valid(ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL stall_timeout got no valid want valid"); end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      stable = (bus.instr_valid === 1'b1) && (bus.instr === rom_fn(15'h0101)) &&
               (pc === 15'h0101) && (bus.rom_req === 1'b0);
      compared++; if (!stable) begin mismatched++; $display("FAIL stall_cycle%0d got valid=%b instr=%h pc=%h req=%b want 1/%h/0101/0", k, bus.instr_valid, bus.instr, pc, bus.rom_req, rom_fn(15'h0101)); end
    end
    sb.push_back(mk(15'h0101));
    halt = 1'b1; bus.instr_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_fetch;
    bit ok;
    halt = 1'b0; bus.instr_ready = 1'b1; ack_delay = 0;
    sb.push_back(mk(15'h0102));
    wait_valid(ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL rstmid_timeout got no valid want valid"); end
    bus.load = 1'b1; bus.jump_addr = 15'h0010; ack_delay = 5;
    @(posedge clk); #1;
    bus.load = 1'b0;
    compared++; if (bus.rom_req !== 1'b1 || bus.rom_addr !== 15'h0010) begin mismatched++; $display("FAIL rstmid_fetch got req=%b addr=%h want 1/0010", bus.rom_req, bus.rom_addr); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    compared++; if (bus.rom_req !== 1'b0) begin mismatched++; $display("FAIL rstmid_req got %b want 0", bus.rom_req); end
    compared++; if (pc !== 15'd0 || bus.instr_valid !== 1'b0) begin mismatched++; $display("FAIL rstmid_state got pc=%h valid=%b want 0000/0", pc, bus.instr_valid); end
    halt = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; ack_delay = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_wrap;
    bit ok;
    halt = 1'b0; bus.instr_ready = 1'b1; ack_delay = 0;
    sb.push_back(mk(15'd0));
    wait_valid(ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL wrap_pre_timeout got no valid want valid"); end
    bus.load = 1'b1; bus.jump_addr = 15'h7FFF;
    @(posedge clk); #1;
    bus.load = 1'b0;
    sb.push_back(mk(15'h7FFF));
    wait_valid(ok);
    compared++; if (!ok || pc !== 15'h7FFF) begin mismatched++; $display("FAIL wrap_at_top got ok=%b pc=%h want 1/7fff", ok, pc); end
    @(posedge clk); #1;
`ifdef HACK_FETCH_WRAP_TRAP_EN
    repeat (2) @(posedge clk); #1;
    compared++; if (wrap_err !== 1'b1) begin mismatched++; $display("FAIL wrap_err got %b want 1", wrap_err); end
    compared++; if (pc !== 15'h7FFF) begin mismatched++; $display("FAIL wrap_pc got %h want 7fff", pc); end
    compared++; if (bus.rom_req !== 1'b0 || bus.instr_valid !== 1'b0) begin mismatched++; $display("FAIL wrap_idle got req=%b valid=%b want 0/0", bus.rom_req, bus.instr_valid); end
`else
    compared++; if (pc !== 15'd0) begin mismatched++; $display("FAIL wrap_pc got %h want 0000", pc); end
    compared++; if (bus.rom_req !== 1'b1 || bus.rom_addr !== 15'd0) begin mismatched++; $display("FAIL wrap_refetch got req=%b addr=%h want 1/0000", bus.rom_req, bus.rom_addr); end
    compared++; if (wrap_err !== 1'b0) begin mismatched++; $display("FAIL wrap_err got %b want 0", wrap_err); end
    sb.push_back(mk(15'd0));
    wait_valid(ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL wrap_post_timeout got no valid want valid"); end
    halt = 1'b1;
    @(posedge clk); #1;
`endif
  endtask

  initial begin
    bus.instr_ready = 1'b0;
    bus.load        = 1'b0;
    bus.jump_addr   = '0;
    test_reset();
    test_sequential();
    test_rom_delay();
    test_jump();
    test_stall();
    test_reset_mid_fetch();
    test_wrap();
    repeat (3) @(posedge clk); #1;
    compared++; if (sb.size() != 0) begin mismatched++; $display("FAIL scoreboard_drain got %0d left want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
